// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings, FSM state type and misalignment helper for dmem_arbiter
package dmem_pkg;

  localparam int DMEM_ADDR_W = 10;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_COMPLETE = 2'd2
  } arb_state_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: misaligned = addr_lo[0];
      SZ_BYTE: misaligned = 1'b0;
      default: misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_fmt.sv
// rtl/dmem_load_fmt.sv - extracts the low byte/half/word of a read word and sign- or zero-extends it
module dmem_load_fmt
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);

  logic sign_b;
  logic sign_h;

  assign sign_b = ~uns_i & word_i[7];
  assign sign_h = ~uns_i & word_i[15];

  always_comb begin
    case (size_i)
      SZ_BYTE: data_o = {{24{sign_b}}, word_i[7:0]};
      SZ_HALF: data_o = {{16{sign_h}}, word_i[15:0]};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter and access sequencer for the data memory
// Optional misalignment check enabled by defining DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic [1:0]        p0_size,
  input  logic              p0_uns,
  output logic              p0_done,
  output logic [31:0]       p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  input  logic [1:0]        p1_size,
  input  logic              p1_uns,
  output logic              p1_done,
  output logic [31:0]       p1_rdata,
  output logic              p1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_size,
  input  logic [31:0]       mem_rdata
);

  arb_state_e        state_q;
  logic              last_q;
  logic              win_q;
  logic              we_q;
  logic              uns_q;
  logic              bad_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic              read_q;
  logic              write_q;
  logic [1:0]        done_q;
  logic [1:0]        err_q;

  logic              win_d;
  logic              we_d;
  logic              uns_d;
  logic              bad_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d;
  logic [1:0]        size_raw;
  logic [1:0]        size_d;
  logic [31:0]       fmt_data;

  // On a tie the port that was not granted last time wins.
  always_comb begin
    if (p0_req && p1_req) begin
      win_d = ~last_q;
    end else begin
      win_d = p1_req;
    end
  end

  always_comb begin
    we_d     = win_d ? p1_we    : p0_we;
    uns_d    = win_d ? p1_uns   : p0_uns;
    addr_d   = win_d ? p1_addr  : p0_addr;
    wdata_d  = win_d ? p1_wdata : p0_wdata;
    size_raw = win_d ? p1_size  : p0_size;
    size_d   = (size_raw == 2'd3) ? SZ_WORD : size_raw;
  end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign bad_d = misaligned(size_d, addr_d[1:0]);
`else
  assign bad_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      bad_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      done_q  <= '0;
      err_q   <= '0;
      case (state_q)
        ST_IDLE: begin
          if (p0_req || p1_req) begin
            win_q   <= win_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            bad_q   <= bad_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            // Strobes are registered so they are high for exactly the ISSUE cycle.
            read_q  <= ~we_d & ~bad_d;
            write_q <= we_d & ~bad_d;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          done_q  <= win_q ? 2'b10 : 2'b01;
          err_q   <= win_q ? {bad_q, 1'b0} : {1'b0, bad_q};
          state_q <= ST_COMPLETE;
        end
        ST_COMPLETE: begin
          last_q  <= win_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  dmem_load_fmt u_load_fmt (
    .word_i (mem_rdata),
    .size_i (size_q),
    .uns_i  (uns_q),
    .data_o (fmt_data)
  );

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_size  = size_q;
  assign mem_read  = read_q;
  assign mem_write = write_q;

  assign p0_done  = done_q[0];
  assign p1_done  = done_q[1];
  assign p0_err   = err_q[0];
  assign p1_err   = err_q[1];
  assign p0_rdata = (done_q[0] && !we_q && !bad_q) ? fmt_data : 32'd0;
  assign p1_rdata = (done_q[1] && !we_q && !bad_q) ? fmt_data : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a byte-array memory model
module tb_dmem_arbiter;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0, p0_uns = 1'b0;
  logic [9:0]  p0_addr = '0;
  logic [31:0] p0_wdata = '0;
  logic [1:0]  p0_size = '0;
  logic        p1_req = 1'b0, p1_we = 1'b0, p1_uns = 1'b0;
  logic [9:0]  p1_addr = '0;
  logic [31:0] p1_wdata = '0;
  logic [1:0]  p1_size = '0;
  logic        p0_done, p0_err, p1_done, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read, mem_write;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata = '0;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rd_cnt = 0;
  exp_t q0[$];
  exp_t q1[$];

  logic [7:0] mem [1024];
  bit         mem_cleared = 1'b0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_size(p0_size), .p0_uns(p0_uns), .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_size(p1_size), .p1_uns(p1_uns), .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memory, little-endian, wrapping modulo 1024.
  always @(posedge clk) begin
    int nb;
    logic [9:0] a;
    if (!mem_cleared) begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      mem_cleared = 1'b1;
    end
    if (mem_write) begin
      nb = (mem_size == 2'd1) ? 2 : (mem_size == 2'd2) ? 1 : 4;
      for (int i = 0; i < nb; i++) begin
        a = mem_addr + 10'(i);
        mem[a] = mem_wdata[8*i +: 8];
      end
    end
    if (mem_read) begin
      for (int i = 0; i < 4; i++) begin
        a = mem_addr + 10'(i);
        mem_rdata[8*i +: 8] <= mem[a];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon_port(input int p, input logic done, input logic [31:0] rdata, input logic err);
    exp_t e;
    if (done) begin
      if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
        checks++;
        failures++;
        $display("FAIL p%0d_unexpected_done: got done at cycle %0d expected none", p, cyc);
      end else begin
        e = (p == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("p%0d_rdata", p), rdata, e.rdata);
        chk($sformatf("p%0d_err", p), {31'd0, err}, {31'd0, e.err});
        chk($sformatf("p%0d_done_cycle", p), cyc, e.cyc);
      end
    end else begin
      chk($sformatf("p%0d_idle_rdata", p), rdata, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_port(0, p0_done, p0_rdata, p0_err);
      mon_port(1, p1_done, p1_rdata, p1_err);
      if (mem_read) rd_cnt++;
    end
  end

  task automatic issue(input int port, input logic we, input logic [9:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                       input bit expect_done);
    exp_t e;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.cyc   = cyc + lat;
    if (port == 0) begin
      p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_size = size; p0_uns = uns; p0_req = 1'b1;
      if (expect_done) q0.push_back(e);
    end else begin
      p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_size = size; p1_uns = uns; p1_req = 1'b1;
      if (expect_done) q1.push_back(e);
    end
  endtask

  task automatic drop(input int port);
    if (port == 0) p0_req = 1'b0;
    else p1_req = 1'b0;
  endtask

  task automatic run1(input int port, input logic we, input logic [9:0] addr,
                      input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                      input logic [31:0] exp_rdata, input logic exp_err);
    issue(port, we, addr, wdata, size, uns, exp_rdata, exp_err, 2, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    drop(port);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_p0_done"}, {31'd0, p0_done}, 32'd0);
    chk({tag, "_p1_done"}, {31'd0, p1_done}, 32'd0);
    chk({tag, "_p0_rdata"}, p0_rdata, 32'd0);
    chk({tag, "_p1_rdata"}, p1_rdata, 32'd0);
    chk({tag, "_errs"}, {30'd0, p1_err, p0_err}, 32'd0);
    chk({tag, "_strobes"}, {30'd0, mem_write, mem_read}, 32'd0);
    chk({tag, "_mem_addr"}, {22'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_size"}, {30'd0, mem_size}, 32'd0);
  endtask

  initial begin
    int rd_before;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Byte store then signed and unsigned byte loads.
    run1(0, 1'b1, 10'h010, 32'h000000A5, 2'd2, 1'b0, 32'h00000000, 1'b0);
    run1(0, 1'b0, 10'h010, 32'h0,        2'd2, 1'b0, 32'hFFFFFFA5, 1'b0);
    run1(0, 1'b0, 10'h010, 32'h0,        2'd2, 1'b1, 32'h000000A5, 1'b0);
    run1(0, 1'b1, 10'h020, 32'h0000BEEF, 2'd1, 1'b0, 32'h00000000, 1'b0);
    run1(0, 1'b0, 10'h020, 32'h0,        2'd1, 1'b0, 32'hFFFFBEEF, 1'b0);
    run1(0, 1'b0, 10'h020, 32'h0,        2'd1, 1'b1, 32'h0000BEEF, 1'b0);

    // Tie: port 0 wins (last=1 after the port-0 run leaves last=0? no: last=0 now, so re-reset first).
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(0, 1'b0, 10'h010, 32'h0, 2'd0, 1'b0, 32'h000000A5, 1'b0, 2, 1'b1);
    issue(1, 1'b0, 10'h010, 32'h0, 2'd2, 1'b0, 32'hFFFFFFA5, 1'b0, 5, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    // Port 0 presents a new payload straight away; port 1 must win this tie.
    issue(0, 1'b0, 10'h010, 32'h0, 2'd1, 1'b0, 32'h000000A5, 1'b0, 5, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    drop(1);
    repeat (3) @(posedge clk);
    #1;
    drop(0);

    // Top-of-memory wrap.
    run1(1, 1'b1, 10'h3FC, 32'h12345678, 2'd0, 1'b0, 32'h00000000, 1'b0);
    run1(1, 1'b0, 10'h3FE, 32'h0,        2'd1, 1'b0, 32'h00001234, 1'b0);
    run1(1, 1'b0, 10'h3FF, 32'h0,        2'd2, 1'b0, 32'h00000012, 1'b0);
    run1(0, 1'b0, 10'h3FC, 32'h0,        2'd3, 1'b0, 32'h12345678, 1'b0);
    run1(0, 1'b0, 10'h3FC, 32'h0,        2'd1, 1'b0, 32'h00005678, 1'b0);

    // Misaligned word load.
    rd_before = rd_cnt;
    run1(0, 1'b0, 10'h005, 32'h0, 2'd0, 1'b0, 32'h00000000, ALIGN_EN);
    chk("misalign_mem_read_pulses", 32'(rd_cnt - rd_before), ALIGN_EN ? 32'd0 : 32'd1);

    // Reset during ISSUE: the abandoned load must not complete, the held request reissues.
    issue(0, 1'b0, 10'h3FC, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_reset_mem_read", {31'd0, mem_read}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outputs("midreset");
    rst = 1'b0;
    issue(0, 1'b0, 10'h3FC, 32'h0, 2'd0, 1'b0, 32'h12345678, 1'b0, 2, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    drop(0);

    repeat (4) @(posedge clk);
    #1;
    chk("p0_pending_left", q0.size(), 32'd0);
    chk("p1_pending_left", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-port byte-addressed data memory (1 KiB, synchronous read, 4-byte little-endian read word). It shares the memory between the core load/store unit (port 0) and the debug/program loader (port 1). It drives the memory control, address, write-data and access-size pins, and returns load data to the requester, formatted by size and signedness. One access is in flight at a time.

## Interface
- `ADDR_W`, 10, byte-address width (1 KiB memory)
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `pN_req`  in  1  port N (N=0,1) request; held with payload until `pN_done`
- `pN_we`  in  1  1 = store, 0 = load
- `pN_addr`  in  ADDR_W  byte address
- `pN_wdata`  in  32  store data, LSB-aligned
- `pN_size`  in  2  0 word, 1 half, 2 byte (3 treated as word)
- `pN_uns`  in  1  load zero-extends when 1, sign-extends when 0
- `pN_done`  out  1  one-cycle completion pulse
- `pN_rdata`  out  32  formatted load data, valid with `pN_done`, else 0
- `pN_err`  out  1  misaligned access flag, valid with `pN_done`
- `mem_addr`  out  ADDR_W  to memory address
- `mem_wdata`  out  32  to memory write data
- `mem_read`, `mem_write`  out  1  memory strobes
- `mem_size`  out  2  memory access size
- `mem_rdata`  in  32  memory read word, valid the cycle after `mem_read`

## Operation
- FSM states: IDLE, ISSUE, COMPLETE.
- IDLE: if any `req` is high, select a winner and capture its payload into registers. Then go to ISSUE. Otherwise stay.
- Winner selection is round-robin. Pointer `last` holds the last granted port. When both ports request, the port other than `last` wins. A single requester always wins. `last` resets to 1, so port 0 wins the first tie.
- ISSUE: drive `mem_*` from the captured registers. Assert `mem_read` = !we or `mem_write` = we for exactly this cycle. Go to COMPLETE.
- COMPLETE: pulse the winner's `done` and drive its `rdata`/`err`. Update `last`. Go to IDLE. Requests are not sampled in this state.
- Load formatting uses offset 0 of `mem_rdata`:
  - byte: `[7:0]`
  - half: `[15:0]`
  - word: all 32 bits
  - Extension per `uns`.
- Stores return `rdata` = 0.
- Outside ISSUE: `mem_read` = `mem_write` = 0. `mem_addr`, `mem_wdata` and `mem_size` hold their last values.
- Address top wrap (e.g. word at 0x3FE) is passed through unchanged. The memory wraps modulo 1024.
- Requester rule: after seeing `done`, drop `req` the next cycle or present a new payload.

## Timing
- Request sampled in IDLE at edge T. `mem_*` strobe during cycle T+1. `done` during cycle T+2. The next request can be sampled at T+3.
- Throughput: one access per 3 cycles. A stalled port waits at most one other access.
- Reset values: state IDLE, `last` = 1, all `done`/`err`/`mem_read`/`mem_write` = 0, all `rdata` = 0, `mem_addr` = 0, `mem_wdata` = 0, `mem_size` = 0.
- Reset mid-access: any in-flight access is abandoned and no `done` is produced. If reset lands in ISSUE, the store has been presented to the memory. Requesters still holding `req` are re-arbitrated after reset.

## Configuration
- `DMEM_ARB_ALIGN_CHECK_EN` defined:
  - half with `addr[0]` = 1, or word with `addr[1:0]` != 0, is misaligned.
  - A misaligned access skips the memory (no strobe in ISSUE) and completes with `err` = 1 and `rdata` = 0.
  - Same 3-cycle timing as a normal access.
- Not defined: no check is made, `err` is tied to 0, and all accesses reach the memory.

## Structure
- Shared package `dmem_pkg`:
  - size encodings: `SZ_WORD` = 0, `SZ_HALF` = 1, `SZ_BYTE` = 2
  - FSM state typedef
  - `DMEM_ADDR_W` = 10
- Sub-module `dmem_load_fmt`: combinational extract and sign/zero extend from (word, size, uns).

## Test plan
- Port 0 byte store 0xA5 to 0x010, then signed byte load from 0x010 -> `rdata` = 0xFFFFFFA5, `done` at T+2. Same load with `uns` = 1 -> 0x000000A5.
- Both ports request loads at once after reset -> port 0 served first, port 1 `done` 3 cycles later. Repeat with both requesting -> port 1 served first.
- Port 1 word store 0x12345678 to 0x3FC, half load from 0x3FE `uns` = 0 -> 0x00001234. Byte load from 0x3FF -> 0x00000012.
- With the macro defined, word load from 0x005 -> `err` = 1, `rdata` = 0, `mem_read` never asserted. Without the macro -> `err` = 0 and `mem_read` pulses.
- Assert `rst` during ISSUE of a port 0 load with `req` held -> no `done`, outputs at reset values. The load reissues and completes 3 cycles after reset release.
